// File: rtl/msg_streamer_pkg.sv
// Shared definitions for msg_streamer: FSM state type and the constant message ROM contents.
package msg_streamer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int unsigned MSG_CHARS = 14;
    localparam logic [8*MSG_CHARS-1:0] MSG_TEXT = "Soy de Zacapa ";

    // Indices past the stored text repeat it, so any MSG_LEN up to 256 is covered.
    function automatic logic [7:0] msg_char(input int unsigned i);
        int unsigned k;
        k = i % MSG_CHARS;
        return MSG_TEXT[8*(MSG_CHARS-1-k) +: 8];
    endfunction

endpackage

// File: rtl/msg_rom.sv
// Combinational index-to-character lookup for msg_streamer.
module msg_rom
    import msg_streamer_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AW     = 4
) (
    input  logic [AW-1:0]     idx,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = DATA_W'(msg_char(32'(idx)));
    end

endmodule

// File: rtl/msg_streamer.sv
// Rate-divided constant message streamer with start/stop, loop mode, valid strobe and done pulse.
// Define MSG_STREAMER_CKSUM_EN to append an XOR checksum emit after each pass.
module msg_streamer
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MSG_LEN = 14,
    parameter int unsigned DIV_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [DIV_W-1:0]  rate,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              busy,
    output logic              done
);
    import msg_streamer_pkg::*;

    localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(MSG_LEN - 1);

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     idx;
    logic [DIV_W-1:0]  div;
    logic [DATA_W-1:0] rom_char;
    logic              emit;
    logic              last_emit;

    msg_rom #(
        .DATA_W(DATA_W),
        .AW    (AW)
    ) u_rom (
        .idx  (idx),
        .data (rom_char)
    );

`ifdef MSG_STREAMER_CKSUM_EN
    logic              cks_pend;
    logic [DATA_W-1:0] cks_acc;
`endif

    always_comb begin
        emit = (state == RUN) && (div == '0);
`ifdef MSG_STREAMER_CKSUM_EN
        last_emit = emit && cks_pend;
`else
        last_emit = emit && (idx == LAST_IDX);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ena) begin
            if (stop) begin
                state_next = IDLE;
            end else begin
                case (state)
                    IDLE:    if (start) state_next = RUN;
                    RUN:     if (last_emit && !loop_en) state_next = DONE;
                    DONE:    state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    always_comb begin
        busy = (state != IDLE);
        done = ena && (state == DONE);
    end

    // Datapath shares the FSM's ena/stop gating; data_valid is the only register cleared while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            div        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
`ifdef MSG_STREAMER_CKSUM_EN
            cks_pend   <= 1'b0;
            cks_acc    <= '0;
`endif
        end else if (!ena) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (stop) begin
                idx <= '0;
                div <= '0;
`ifdef MSG_STREAMER_CKSUM_EN
                cks_pend <= 1'b0;
`endif
            end else if (state == IDLE) begin
                if (start) begin
                    idx <= '0;
                    div <= '0;
`ifdef MSG_STREAMER_CKSUM_EN
                    cks_pend <= 1'b0;
                    cks_acc  <= '0;
`endif
                end
            end else if (state == RUN) begin
                if (!emit) begin
                    div <= div - 1'b1;
                end else begin
                    data_valid <= 1'b1;
                    div        <= rate;
`ifdef MSG_STREAMER_CKSUM_EN
                    if (cks_pend) begin
                        data_out <= cks_acc;
                        cks_pend <= 1'b0;
                        cks_acc  <= '0;
                        idx      <= '0;
                    end else begin
                        data_out <= rom_char;
                        cks_acc  <= cks_acc ^ rom_char;
                        if (idx == LAST_IDX) begin
                            cks_pend <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
`else
                    data_out <= rom_char;
                    idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_msg_streamer.sv
// Scoreboard bench for msg_streamer: stimulus pushes expected emits (by active-cycle index), a monitor pops and compares.
module tb_msg_streamer;

    localparam int DW = 8;
    localparam int ML = 14;
    localparam int DV = 8;
`ifdef MSG_STREAMER_CKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int P = ML + CK;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          ena     = 1'b0;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic          loop_en = 1'b0;
    logic [DV-1:0] rate    = '0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          busy;
    logic          done;

    typedef struct {
        int         t;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    int         dq[$];
    int         total    = 0;
    int         bad      = 0;
    int         act_cnt  = 0;
    logic       last_act = 1'b0;
    logic       ev, ed;
    logic [7:0] msg [0:13] = '{8'h53, 8'h6F, 8'h79, 8'h20, 8'h64, 8'h65, 8'h20,
                               8'h5A, 8'h61, 8'h63, 8'h61, 8'h70, 8'h61, 8'h20};
    logic [7:0] ck_val;

    msg_streamer #(
        .DATA_W (DW),
        .MSG_LEN(ML),
        .DIV_W  (DV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .rate      (rate),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Active-edge counter: emits are scheduled in edges where the block was enabled.
    always @(posedge clk) begin
        last_act = ena && rst_n;
        if (ena && rst_n) act_cnt++;
    end

    always @(negedge clk) begin
        ev = last_act && (sb.size() > 0) && (sb[0].t == act_cnt);
        if (ev || data_valid) chk("valid", data_valid, ev);
        if (ev) begin
            chk("data", data_out, sb[0].d);
            void'(sb.pop_front());
        end
        ed = last_act && ena && (dq.size() > 0) && (dq[0] == act_cnt);
        if (ed || done) chk("done", done, ed);
        if (last_act && (dq.size() > 0) && (dq[0] == act_cnt)) void'(dq.pop_front());
    end

    function automatic void push_pass(input int s, input int r, input int n, input bit lp,
                                      output int last_t);
        int t, pos;
        last_t = s;
        for (int i = 0; i < n; i++) begin
            t   = s + 1 + i * (r + 1);
            pos = i % P;
            sb.push_back('{t, (pos < ML) ? msg[pos] : ck_val});
            if (!lp && pos == P - 1) dq.push_back(t);
            last_t = t;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int r, input int n, input bit lp, output int s, output int last_t);
        rate    = DV'(r);
        loop_en = lp;
        s       = act_cnt + 1;
        push_pass(s, r, n, lp, last_t);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_act(input int tgt);
        for (int i = 0; i < 3000; i++) begin
            if (act_cnt >= tgt) return;
            tick();
        end
        total++;
        bad++;
        $display("FAIL wait_act: timeout at act %0d expected %0d", act_cnt, tgt);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            if (sb.size() == 0 && dq.size() == 0) begin
                tick();
                tick();
                return;
            end
            tick();
        end
        total++;
        bad++;
        $display("FAIL drain: timeout with %0d emits pending expected 0", sb.size());
        sb.delete();
        dq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, lt, r, k, off, len;
        ck_val = '0;
        for (int i = 0; i < ML; i++) ck_val ^= msg[i];

        #2 rst_n = 1'b0;
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        ena = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back characters, single pass.
        do_start(0, P, 0, s, lt);
        chk("busy_run", busy, 1);
        wait_drain();
        chk("busy_after_pass", busy, 0);

        // Spaced characters.
        do_start(3, P, 0, s, lt);
        wait_drain();
        chk("busy_after_rate3", busy, 0);

        // Loop mode through two wraps, then abort.
        do_start(0, 2 * P + 5, 1, s, lt);
        wait_act(lt);
        stop    = 1'b1;
        loop_en = 1'b0;
        tick();
        stop = 1'b0;
        wait_drain();
        chk("busy_after_loop_stop", busy, 0);

        // Stop right at the 5th character.
        do_start(1, 5, 0, s, lt);
        wait_act(lt);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
        chk("busy_after_stop", busy, 0);
        chk("hold_after_stop", data_out, msg[4]);
        repeat (6) tick();

        // start and stop together leave the block idle.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        repeat (4) tick();
        chk("busy_start_stop", busy, 0);

        do_start(0, P, 0, s, lt);
        wait_drain();

        // Freeze for 10 cycles mid-hold.
        do_start(2, P, 0, s, lt);
        wait_act(s + 1 + 5 * 3 + 1);
        ena = 1'b0;
        repeat (10) tick();
        chk("busy_frozen", busy, 1);
        ena = 1'b1;
        wait_drain();

        // Randomised rates and freeze points.
        for (int it = 0; it < 5; it++) begin
            r   = $urandom_range(0, 5);
            k   = $urandom_range(1, 10);
            off = $urandom_range(0, r);
            len = $urandom_range(1, 8);
            do_start(r, P, 0, s, lt);
            wait_act(s + 1 + k * (r + 1) + off);
            ena = 1'b0;
            repeat (len) tick();
            ena = 1'b1;
            wait_drain();
        end

        // Reset in the middle of a pass: no done, outputs back to reset values.
        do_start(0, P, 0, s, lt);
        wait_act(s + 4);
        rst_n = 1'b0;
        sb.delete();
        dq.delete();
        #1;
        chk("midrst_data_out", data_out, 0);
        chk("midrst_valid", data_valid, 0);
        chk("midrst_busy", busy, 0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("busy_after_midrst", busy, 0);

        do_start(1, P, 0, s, lt);
        wait_drain();

        repeat (5) tick();
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
